// File: rtl/rgb_to_yuv_pkg.sv
// Shared constants for the BT.601 full-range RGB->YUV converter:
// coefficient matrix (x/256), rounding constant and fraction shift.
package rgb_to_yuv_pkg;

   localparam int DTYPE_WIDTH = 8;

   localparam int C_Y_R = 77;
   localparam int C_Y_G = 150;
   localparam int C_Y_B = 29;
   localparam int C_U_R = -43;
   localparam int C_U_G = -85;
   localparam int C_U_B = 128;
   localparam int C_V_R = 128;
   localparam int C_V_G = -107;
   localparam int C_V_B = -21;

   localparam int ROUND_CONST = 128;
   localparam int FRAC_SHIFT  = 8;

   // row 0=Y, 1=U, 2=V; col 0=R, 1=G, 2=B
   function automatic int coeff(input int row, input int col);
      case (row * 3 + col)
         0:       return C_Y_R;
         1:       return C_Y_G;
         2:       return C_Y_B;
         3:       return C_U_R;
         4:       return C_U_G;
         5:       return C_U_B;
         6:       return C_V_R;
         7:       return C_V_G;
         8:       return C_V_B;
         default: return 0;
      endcase
   endfunction

endpackage

// File: rtl/rgb_to_yuv_if.sv
// Pixel stream in (rgb) and out (yuv) with side-band dv/dtype/meta.
interface rgb_to_yuv_if
   import rgb_to_yuv_pkg::*;
#(
   parameter int PIXEL_WIDTH = 8
);
   logic                   enable;
   logic                   dvi;
   logic [DTYPE_WIDTH-1:0] dtypei;
   logic [PIXEL_WIDTH-1:0] ri;
   logic [PIXEL_WIDTH-1:0] gi;
   logic [PIXEL_WIDTH-1:0] bi;
   logic [15:0]            meta_datai;
   logic                   dvo;
   logic [DTYPE_WIDTH-1:0] dtypeo;
   logic [PIXEL_WIDTH-1:0] yo;
   logic [PIXEL_WIDTH-1:0] uo;
   logic [PIXEL_WIDTH-1:0] vo;
   logic [15:0]            meta_datao;

   modport master (
      output enable, dvi, dtypei, ri, gi, bi, meta_datai,
      input  dvo, dtypeo, yo, uo, vo, meta_datao
   );

   modport slave (
      input  enable, dvi, dtypei, ri, gi, bi, meta_datai,
      output dvo, dtypeo, yo, uo, vo, meta_datao
   );
endinterface

// File: rtl/rgb_to_yuv_row.sv
// One output channel: registered products, registered rounded sum, and a
// combinational shift+clamp feeding the top's output register.
module rgb_to_yuv_row
   import rgb_to_yuv_pkg::*;
#(
   parameter int PIXEL_WIDTH = 8,
   parameter int COEFF_WIDTH = 9,
   parameter bit SIGNED_OUT  = 1'b0
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          ld1_i,
   input  logic                          ld2_i,
   input  logic        [PIXEL_WIDTH-1:0] pix_i   [3],
   input  logic signed [COEFF_WIDTH-1:0] coeff_i [3],
   output logic        [PIXEL_WIDTH-1:0] res_o
);
   localparam int PROD_W = PIXEL_WIDTH + COEFF_WIDTH + 1;
   localparam int SUM_W  = PROD_W + 2;

   localparam logic signed [SUM_W-1:0] HI = SIGNED_OUT ? (2 ** (PIXEL_WIDTH - 1)) - 1
                                                       : (2 ** PIXEL_WIDTH) - 1;
   localparam logic signed [SUM_W-1:0] LO = SIGNED_OUT ? -(2 ** (PIXEL_WIDTH - 1)) : 0;

   logic signed [PROD_W-1:0] prod_q [3];
   logic signed [SUM_W-1:0]  sum_d;
   logic signed [SUM_W-1:0]  sum_q;
   logic signed [SUM_W-1:0]  shifted;

   for (genvar gi = 0; gi < 3; gi++) begin : g_prod
      logic signed [PROD_W-1:0] coeff_ext;
      logic signed [PROD_W-1:0] pix_ext;
      assign coeff_ext = PROD_W'(coeff_i[gi]);
      assign pix_ext   = $signed(PROD_W'({1'b0, pix_i[gi]}));

      always_ff @(posedge clk) begin
         if (reset) begin
            prod_q[gi] <= '0;
         end else if (ld1_i) begin
            prod_q[gi] <= coeff_ext * pix_ext;
         end
      end
   end

   assign sum_d = SUM_W'(prod_q[0]) + SUM_W'(prod_q[1]) + SUM_W'(prod_q[2])
                + SUM_W'(ROUND_CONST);

   always_ff @(posedge clk) begin
      if (reset) begin
         sum_q <= '0;
      end else if (ld2_i) begin
         sum_q <= sum_d;
      end
   end

   // floor division by 256 then saturate to the channel's range
   always_comb begin
      shifted = sum_q >>> FRAC_SHIFT;
      res_o   = shifted[PIXEL_WIDTH-1:0];
      if (shifted > HI) begin
         res_o = HI[PIXEL_WIDTH-1:0];
      end else if (shifted < LO) begin
         res_o = LO[PIXEL_WIDTH-1:0];
      end
   end

endmodule

// File: rtl/rgb_to_yuv.sv
// BT.601 full-range RGB->YUV, fixed 3-cycle latency, per-pixel bypass.
// Side-band fields shift every cycle; pixel data loads only on stage valid.
module rgb_to_yuv
   import rgb_to_yuv_pkg::*;
#(
   parameter int PIXEL_WIDTH = 8,
   parameter int COEFF_WIDTH = 9
) (
   input logic         clk,
   input logic         reset,
   rgb_to_yuv_if.slave bus
);
   logic                   dv_q    [3];
   logic                   en_q    [2];
   logic [DTYPE_WIDTH-1:0] dtype_q [3];
   logic [15:0]            meta_q  [3];
   logic [PIXEL_WIDTH-1:0] pix_in  [3];
   logic [PIXEL_WIDTH-1:0] pix1_q  [3];
   logic [PIXEL_WIDTH-1:0] pix2_q  [3];
   logic [PIXEL_WIDTH-1:0] row_res [3];
   logic [PIXEL_WIDTH-1:0] out_q   [3];

   assign pix_in[0] = bus.ri;
   assign pix_in[1] = bus.gi;
   assign pix_in[2] = bus.bi;

   for (genvar gi = 0; gi < 3; gi++) begin : g_row
      logic signed [COEFF_WIDTH-1:0] coeff_row [3];
      for (genvar ci = 0; ci < 3; ci++) begin : g_coeff
         assign coeff_row[ci] = COEFF_WIDTH'(coeff(gi, ci));
      end

      rgb_to_yuv_row #(
         .PIXEL_WIDTH (PIXEL_WIDTH),
         .COEFF_WIDTH (COEFF_WIDTH),
         .SIGNED_OUT  (gi != 0)
      ) u_row (
         .clk     (clk),
         .reset   (reset),
         .ld1_i   (bus.dvi),
         .ld2_i   (dv_q[0]),
         .pix_i   (pix_in),
         .coeff_i (coeff_row),
         .res_o   (row_res[gi])
      );

      // raw pixels travel alongside the arithmetic so bypass can pick them
      always_ff @(posedge clk) begin
         if (reset) begin
            pix1_q[gi] <= '0;
            pix2_q[gi] <= '0;
            out_q[gi]  <= '0;
         end else begin
            if (bus.dvi)  pix1_q[gi] <= pix_in[gi];
            if (dv_q[0])  pix2_q[gi] <= pix1_q[gi];
            if (dv_q[1])  out_q[gi]  <= en_q[1] ? row_res[gi] : pix2_q[gi];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 3; i++) begin
            dv_q[i]    <= 1'b0;
            dtype_q[i] <= '0;
            meta_q[i]  <= '0;
         end
         en_q[0] <= 1'b0;
         en_q[1] <= 1'b0;
      end else begin
         dv_q[0]    <= bus.dvi;
         dtype_q[0] <= bus.dtypei;
         meta_q[0]  <= bus.meta_datai;
         en_q[0]    <= bus.enable;
         en_q[1]    <= en_q[0];
         for (int i = 1; i < 3; i++) begin
            dv_q[i]    <= dv_q[i-1];
            dtype_q[i] <= dtype_q[i-1];
            meta_q[i]  <= meta_q[i-1];
         end
      end
   end

   assign bus.dvo        = dv_q[2];
   assign bus.dtypeo     = dtype_q[2];
   assign bus.meta_datao = meta_q[2];
   assign bus.yo         = out_q[0];
   assign bus.uo         = out_q[1];
   assign bus.vo         = out_q[2];

endmodule

// File: tb/tb_rgb_to_yuv.sv
// Directed and random checks of rgb_to_yuv against hand-computed and
// integer-model expectations, one line per transaction.
module tb_rgb_to_yuv;
   import rgb_to_yuv_pkg::*;

   typedef struct {
      bit        dv;
      logic [7:0]  dt;
      logic [15:0] meta;
      logic [7:0]  y;
      logic [7:0]  u;
      logic [7:0]  v;
   } rec_t;

   logic clk = 1'b0;
   logic reset;
   int   tests_run    = 0;
   int   tests_failed = 0;
   int   step_no      = 0;
   rec_t pipe [3];
   rec_t last_out;

   rgb_to_yuv_if #(.PIXEL_WIDTH(8)) bus ();

   rgb_to_yuv #(.PIXEL_WIDTH(8), .COEFF_WIDTH(9)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s step=%0d actual=%0h expected=%0h", tag, step_no, act, exp);
      end
   endtask

   function automatic logic [7:0] ref_row(input int c0, input int c1, input int c2,
                                          input int r, input int g, input int b,
                                          input bit sgn);
      int s;
      s = (c0 * r + c1 * g + c2 * b + 128) >>> 8;
      if (sgn) begin
         if (s > 127)  s = 127;
         if (s < -128) s = -128;
      end else begin
         if (s > 255) s = 255;
         if (s < 0)   s = 0;
      end
      return s[7:0];
   endfunction

   task automatic clear_pipe();
      for (int i = 0; i < 3; i++) pipe[i] = '{1'b0, 8'h0, 16'h0, 8'h0, 8'h0, 8'h0};
      last_out = '{1'b0, 8'h0, 16'h0, 8'h0, 8'h0, 8'h0};
   endtask

   // apply one input cycle, then check what emerges this cycle
   task automatic step(input bit rst, input bit dv, input bit en,
                       input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                       input logic [7:0] dt, input logic [15:0] meta,
                       input logic [7:0] ey, input logic [7:0] eu, input logic [7:0] ev);
      rec_t cur;
      reset          = rst;
      bus.dvi        = dv;
      bus.enable     = en;
      bus.ri         = r;
      bus.gi         = g;
      bus.bi         = b;
      bus.dtypei     = dt;
      bus.meta_datai = meta;
      cur = '{dv, dt, meta, ey, eu, ev};
      @(posedge clk);
      #1;
      step_no++;
      if (rst) begin
         clear_pipe();
      end else begin
         pipe[2] = pipe[1];
         pipe[1] = pipe[0];
         pipe[0] = cur;
      end
      check("dvo",   {31'd0, bus.dvo},    {31'd0, pipe[2].dv});
      check("dtype", {24'd0, bus.dtypeo}, {24'd0, pipe[2].dt});
      check("meta",  {16'd0, bus.meta_datao}, {16'd0, pipe[2].meta});
      if (pipe[2].dv) last_out = pipe[2];
      check("y", {24'd0, bus.yo}, {24'd0, last_out.y});
      check("u", {24'd0, bus.uo}, {24'd0, last_out.u});
      check("v", {24'd0, bus.vo}, {24'd0, last_out.v});
      if (bus.dvo)
         $display("[TB] step %0d out y=%02h u=%02h v=%02h meta=%04h", step_no,
                  bus.yo, bus.uo, bus.vo, bus.meta_datao);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b1, 8'h0, 8'h0, 8'h0, 8'h0, 16'h0, 8'h0, 8'h0, 8'h0);
   endtask

   initial begin
      clear_pipe();
      // reset state
      step(1'b1, 1'b0, 1'b0, 8'h0, 8'h0, 8'h0, 8'h0, 16'h0, 8'h0, 8'h0, 8'h0);
      step(1'b1, 1'b0, 1'b0, 8'h0, 8'h0, 8'h0, 8'h0, 16'h0, 8'h0, 8'h0, 8'h0);
      idle(2);

      // white: single pulse, dvo only 3 cycles later
      step(1'b0, 1'b1, 1'b1, 8'd255, 8'd255, 8'd255, 8'h11, 16'hA5A5, 8'd255, 8'h00, 8'h00);
      idle(4);

      // primaries back to back, including saturation of U/V
      step(1'b0, 1'b1, 1'b1, 8'd255, 8'd0,   8'd0,   8'h01, 16'h0001, 8'd77,  8'hD5, 8'h7F);
      step(1'b0, 1'b1, 1'b1, 8'd0,   8'd0,   8'd255, 8'h02, 16'h0002, 8'd29,  8'h7F, 8'hEB);
      step(1'b0, 1'b1, 1'b1, 8'd0,   8'd255, 8'd0,   8'h03, 16'h0003, 8'd149, 8'hAB, 8'h95);
      step(1'b0, 1'b1, 1'b1, 8'd0,   8'd0,   8'd0,   8'h04, 16'h0004, 8'd0,   8'h00, 8'h00);
      idle(3);

      // per-pixel bypass interleave
      for (int k = 0; k < 3; k++) begin
         step(1'b0, 1'b1, 1'b1, 8'd255, 8'd255, 8'd255, 8'h20, 16'h1000, 8'd255, 8'd0,  8'd0);
         step(1'b0, 1'b1, 1'b0, 8'd10,  8'd20,  8'd30,  8'h21, 16'h2000, 8'd10,  8'd20, 8'd30);
      end
      idle(3);

      // gapped stream: outputs hold during dvo=0
      step(1'b0, 1'b1, 1'b1, 8'd255, 8'd255, 8'd255, 8'h30, 16'h1111, 8'd255, 8'h00, 8'h00);
      step(1'b0, 1'b0, 1'b1, 8'd1,   8'd2,   8'd3,   8'h31, 16'h0000, 8'd0,   8'd0,  8'd0);
      step(1'b0, 1'b0, 1'b0, 8'd4,   8'd5,   8'd6,   8'h32, 16'h0000, 8'd0,   8'd0,  8'd0);
      step(1'b0, 1'b1, 1'b1, 8'd255, 8'd0,   8'd0,   8'h33, 16'h2222, 8'd77,  8'hD5, 8'h7F);
      step(1'b0, 1'b1, 1'b1, 8'd0,   8'd0,   8'd255, 8'h34, 16'h3333, 8'd29,  8'h7F, 8'hEB);
      step(1'b0, 1'b0, 1'b1, 8'd9,   8'd9,   8'd9,   8'h35, 16'h0000, 8'd0,   8'd0,  8'd0);
      idle(4);

      // mid-stream reset flushes two in-flight pixels
      step(1'b0, 1'b1, 1'b0, 8'd50, 8'd60, 8'd70, 8'h40, 16'h4444, 8'd50, 8'd60, 8'd70);
      step(1'b0, 1'b1, 1'b1, 8'd255, 8'd255, 8'd255, 8'h41, 16'h5555, 8'd255, 8'd0, 8'd0);
      step(1'b1, 1'b0, 1'b1, 8'd0, 8'd0, 8'd0, 8'h00, 16'h0000, 8'd0, 8'd0, 8'd0);
      idle(2);
      step(1'b0, 1'b1, 1'b0, 8'd7, 8'd8, 8'd9, 8'h42, 16'h6666, 8'd7, 8'd8, 8'd9);
      idle(4);

      // random sweep against integer model
      for (int n = 0; n < 2000; n++) begin
         logic [7:0]  r, g, b, dt, ey, eu, ev;
         logic [15:0] meta;
         bit          dv, en;
         r    = 8'($urandom_range(0, 255));
         g    = 8'($urandom_range(0, 255));
         b    = 8'($urandom_range(0, 255));
         dt   = 8'($urandom_range(0, 255));
         meta = 16'($urandom_range(0, 65535));
         dv   = ($urandom_range(0, 3) != 0);
         en   = ($urandom_range(0, 3) != 0);
         if (en) begin
            ey = ref_row(77, 150, 29, r, g, b, 1'b0);
            eu = ref_row(-43, -85, 128, r, g, b, 1'b1);
            ev = ref_row(128, -107, -21, r, g, b, 1'b1);
         end else begin
            ey = r;
            eu = g;
            ev = b;
         end
         step(1'b0, dv, en, r, g, b, dt, meta, ey, eu, ev);
      end
      idle(4);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
